// File: rtl/bin2bcd_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
package bin2bcd_serial_pkg;

  // Width of one BCD digit.
  localparam int NIBBLE_W = 4;

  // Converter control states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_bcd_value(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the next shift.
module bcd_add3
  import bin2bcd_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [NIBBLE_W-1:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_serial.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Handshake: start is sampled only while idle (busy=0); an accepted start loads bin_in,
// busy stays high for IN_W cycles, then done pulses for one cycle with bcd_out/ovf
// freshly updated. start while busy is dropped. bcd_out/ovf hold between completions.
// busy is the decoded FSM state (1 = CONV) and doubles as the state observation point.
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [IN_W-1:0]              bin_in,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf,
  output logic [NIBBLE_W*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W) + 1;
  localparam logic [63:0]      MAX      = max_bcd_value(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  state_t           state;
  state_t           state_next;
  logic [SR_W-1:0]  sreg;
  logic [SR_W-1:0]  sreg_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pending;
  logic             ovf_in;
  logic             accept;
  logic             last_bit;

  // Per-digit add-3 correction on the BCD part of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .nibble   (sreg[IN_W + NIBBLE_W*g +: NIBBLE_W]),
      .adjusted (bcd_adj[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  // Corrected digits followed by the remaining binary bits, then one shift left.
  assign sreg_shift = {bcd_adj, sreg[IN_W-1:0]} << 1;

  // Out-of-range inputs are flagged at capture and saturated at completion; when
  // the input width cannot exceed MAX this folds to a constant 0.
  assign ovf_in = (64'(bin_in) > MAX);

  assign busy = (state == ST_CONV);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a start while idle, finish after the last input bit.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cnt == LAST_CNT) begin
          last_bit   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, shift during conversion, publish result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg        <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      bcd_out     <= '0;
    end else begin
      done <= last_bit;
      if (accept) begin
        sreg        <= {{BCD_W{1'b0}}, bin_in};
        cnt         <= '0;
        ovf_pending <= ovf_in;
      end else if (state == ST_CONV) begin
        sreg <= sreg_shift;
        cnt  <= cnt + CNT_W'(1);
      end
      if (last_bit) begin
        bcd_out <= ovf_pending ? {DIGITS{4'h9}} : sreg_shift[SR_W-1 -: BCD_W];
        ovf     <= ovf_pending;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: vector table, random values against a decimal model,
// and directed sequences for busy-ignore, back-to-back and mid-conversion reset.
module tb_bin2bcd_serial;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int LAT    = IN_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [IN_W-1:0]  bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [BCD_W-1:0] bcd_out;

  int n_checks;
  int n_errors;
  logic [BCD_W:0]   exp_q[$];
  logic [BCD_W-1:0] prev_bcd;

  typedef struct {
    logic [IN_W-1:0]  bin;
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } vec_t;

  vec_t vecs[9];

  bin2bcd_serial #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: digit extraction by division, saturation above 10^DIGITS-1.
  function automatic logic [BCD_W:0] model(input int v);
    logic [BCD_W-1:0] r;
    int d;
    int max_v;
    max_v = 1;
    for (int k = 0; k < DIGITS; k++) max_v = max_v * 10;
    max_v = max_v - 1;
    if (v > max_v) begin
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'h9;
      return {1'b1, r};
    end
    d = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return {1'b0, r};
  endfunction

  // Driver + scoreboard for one isolated conversion.
  task automatic run_conv(input logic [IN_W-1:0] v, input logic [BCD_W-1:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int lat;
    logic seen;
    logic [BCD_W:0] e;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = IN_W'($urandom);
    exp_q.push_back({exp_ovf, exp_bcd});
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, " result_held"}, 32'(bcd_out), 32'(prev_bcd));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    e = exp_q.pop_front();
    if (seen) begin
      check({tag, " bcd_out"}, 32'(bcd_out), 32'(e[BCD_W-1:0]));
      check({tag, " ovf"}, 32'(ovf), 32'(e[BCD_W]));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      prev_bcd = bcd_out;
    end
  endtask

  initial begin
    int n_done;
    int lat;
    int cyc;
    int mark;
    logic stable;
    logic [BCD_W-1:0] got;
    logic [BCD_W:0] m;
    int v;

    n_checks = 0;
    n_errors = 0;
    prev_bcd = '0;

    vecs[0] = '{bin: 14'd25,    bcd: 16'h0025, ovf: 1'b0};
    vecs[1] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
    vecs[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
    vecs[3] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
    vecs[4] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
    vecs[5] = '{bin: 14'd42,    bcd: 16'h0042, ovf: 1'b0};
    vecs[6] = '{bin: 14'd1000,  bcd: 16'h1000, ovf: 1'b0};
    vecs[7] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0};
    vecs[8] = '{bin: 14'd8191,  bcd: 16'h8191, ovf: 1'b0};

    // Reset.
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Random values against the decimal model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 9999));
        2:       v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 16383));
      endcase
      m = model(v);
      run_conv(IN_W'(v), m[BCD_W-1:0], m[BCD_W], $sformatf("rand%0d(%0d)", i, v));
    end

    // start pulses while busy are ignored.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd123;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    lat    = -1;
    got    = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= 12) begin
        start  = i[0];
        bin_in = 14'd777;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        lat = i;
        got = bcd_out;
      end
    end
    check("ignore done_count", 32'(n_done), 32'd1);
    check("ignore latency", 32'(lat), 32'(LAT));
    check("ignore bcd_out", 32'(got), 32'h0123);
    check("ignore no_restart", 32'(busy), 32'd0);
    check("ignore final_bcd", 32'(bcd_out), 32'h0123);
    prev_bcd = bcd_out;

    // start held high: back-to-back conversions, alternating 5/31.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5;
    @(posedge clk);
    #1;
    cyc    = 0;
    mark   = 0;
    n_done = 0;
    stable = 1'b1;
    while (n_done < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        check($sformatf("b2b interval%0d", n_done), 32'(cyc - mark),
              (n_done == 0) ? 32'(LAT) : 32'(LAT + 1));
        check($sformatf("b2b bcd%0d", n_done), 32'(bcd_out),
              (n_done % 2 == 0) ? 32'h0005 : 32'h0031);
        check($sformatf("b2b ovf%0d", n_done), 32'(ovf), 32'd0);
        mark = cyc;
        n_done++;
        bin_in = (n_done % 2 == 1) ? 14'd31 : 14'd5;
        if (n_done == 3) start = 1'b0;
        prev_bcd = bcd_out;
      end else if (bcd_out !== prev_bcd) begin
        stable = 1'b0;
      end
    end
    check("b2b done_count", 32'(n_done), 32'd3);
    check("b2b stable_between", 32'(stable), 32'd1);
    @(posedge clk);
    #1;

    // Reset asserted mid-conversion.
    run_conv(14'd25, 16'h0025, 1'b0, "pre_reset");
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd8888;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset ovf", 32'(ovf), 32'd0);
    check("midreset bcd_out", 32'(bcd_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_bcd = '0;
    n_done   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("midreset no_done", 32'(n_done), 32'd0);
    check("midreset idle", 32'(busy), 32'd0);
    run_conv(14'd31, 16'h0031, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
